// File: rtl/iter_muldiv.sv
// iter_muldiv: iterative shift-add multiplier and restoring divider.
// The two engines share clk/rst_n but are otherwise independent. Each takes
// SIZE+1 cycles from accept to result: SIZE iterations plus one sign-fixup
// edge. Define ITER_MULDIV_FAST_DIVZERO_EN to finish divide-by-zero one edge
// after accept. Result values are the same with or without it.
module iter_muldiv #(
    parameter int SIZE = 33
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mul_start,
    input  logic                mul_is_signed,
    input  logic [SIZE-1:0]     mul_multiplicand,
    input  logic [SIZE-1:0]     mul_multiplier,
    output logic                mul_ready,
    output logic                mul_valid,
    output logic [2*SIZE-1:0]   mul_product,
    input  logic                div_start,
    input  logic                div_is_signed,
    input  logic [SIZE-1:0]     div_dividend,
    input  logic [SIZE-1:0]     div_divisor,
    output logic                div_ready,
    output logic                div_valid,
    output logic                div_error,
    output logic [SIZE-1:0]     div_quotient,
    output logic [SIZE-1:0]     div_remainder
);

    localparam int CW = $clog2(SIZE + 1);
    localparam logic [CW-1:0] LAST = CW'(SIZE);

    typedef enum logic {IDLE, BUSY} state_t;

    // Magnitude of a possibly-signed operand. The most negative value maps to
    // 2^(SIZE-1), which still fits in SIZE unsigned bits.
    function automatic logic [SIZE-1:0] mag(input logic [SIZE-1:0] x, input logic s);
        return (s && x[SIZE-1]) ? -x : x;
    endfunction

    // ------------------------------------------------------------------
    // Multiplier
    // ------------------------------------------------------------------
    state_t            mstate_q, mstate_d;
    logic [CW-1:0]     mcnt_q, mcnt_d;
    logic [2*SIZE-1:0] macc_q, macc_d;      // {partial high, shifting multiplier}
    logic [SIZE-1:0]   mmag_q, mmag_d;      // multiplicand magnitude
    logic              mneg_q, mneg_d;
    logic [2*SIZE-1:0] mprod_q, mprod_d;
    logic              mvalid_q, mvalid_d;
    logic [SIZE:0]     msum;

    // Multiplier state and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstate_q <= IDLE;
            mcnt_q   <= '0;
            macc_q   <= '0;
            mmag_q   <= '0;
            mneg_q   <= 1'b0;
            mprod_q  <= '0;
            mvalid_q <= 1'b0;
        end else begin
            mstate_q <= mstate_d;
            mcnt_q   <= mcnt_d;
            macc_q   <= macc_d;
            mmag_q   <= mmag_d;
            mneg_q   <= mneg_d;
            mprod_q  <= mprod_d;
            mvalid_q <= mvalid_d;
        end
    end

    // Multiplier next state: accept, one add-shift per cycle, then sign fixup
    always_comb begin
        mstate_d = mstate_q;
        mcnt_d   = mcnt_q;
        macc_d   = macc_q;
        mmag_d   = mmag_q;
        mneg_d   = mneg_q;
        mprod_d  = mprod_q;
        mvalid_d = 1'b0;
        msum     = {1'b0, macc_q[2*SIZE-1:SIZE]} + (macc_q[0] ? {1'b0, mmag_q} : '0);
        case (mstate_q)
            IDLE: begin
                if (mul_start) begin
                    mstate_d = BUSY;
                    mcnt_d   = '0;
                    mmag_d   = mag(mul_multiplicand, mul_is_signed);
                    macc_d   = {{SIZE{1'b0}}, mag(mul_multiplier, mul_is_signed)};
                    mneg_d   = mul_is_signed & (mul_multiplicand[SIZE-1] ^ mul_multiplier[SIZE-1]);
                end
            end
            BUSY: begin
                if (mcnt_q == LAST) begin
                    mprod_d  = mneg_q ? -macc_q : macc_q;
                    mvalid_d = 1'b1;
                    mstate_d = IDLE;
                end else begin
                    macc_d = {msum, macc_q[SIZE-1:1]};
                    mcnt_d = mcnt_q + CW'(1);
                end
            end
            default: mstate_d = IDLE;
        endcase
    end

    assign mul_ready   = (mstate_q == IDLE);
    assign mul_valid   = mvalid_q;
    assign mul_product = mprod_q;

    // ------------------------------------------------------------------
    // Divider
    // ------------------------------------------------------------------
    state_t          dstate_q, dstate_d;
    logic [CW-1:0]   dcnt_q, dcnt_d;
    logic [SIZE-1:0] drem_q, drem_d;        // partial remainder
    logic [SIZE-1:0] dquo_q, dquo_d;        // dividend bits in, quotient bits out
    logic [SIZE-1:0] dmag_q, dmag_d;        // divisor magnitude
    logic [SIZE-1:0] dend_q, dend_d;        // raw dividend, returned on divide-by-zero
    logic            dqneg_q, dqneg_d;
    logic            drneg_q, drneg_d;
    logic            dzero_q, dzero_d;
    logic [SIZE-1:0] dq_out_q, dq_out_d;
    logic [SIZE-1:0] dr_out_q, dr_out_d;
    logic            derr_q, derr_d;
    logic            dvalid_q, dvalid_d;
    logic [SIZE:0]   dshift;
    logic [SIZE:0]   ddiff;
    logic            dge;

    // Divider state and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dstate_q <= IDLE;
            dcnt_q   <= '0;
            drem_q   <= '0;
            dquo_q   <= '0;
            dmag_q   <= '0;
            dend_q   <= '0;
            dqneg_q  <= 1'b0;
            drneg_q  <= 1'b0;
            dzero_q  <= 1'b0;
            dq_out_q <= '0;
            dr_out_q <= '0;
            derr_q   <= 1'b0;
            dvalid_q <= 1'b0;
        end else begin
            dstate_q <= dstate_d;
            dcnt_q   <= dcnt_d;
            drem_q   <= drem_d;
            dquo_q   <= dquo_d;
            dmag_q   <= dmag_d;
            dend_q   <= dend_d;
            dqneg_q  <= dqneg_d;
            drneg_q  <= drneg_d;
            dzero_q  <= dzero_d;
            dq_out_q <= dq_out_d;
            dr_out_q <= dr_out_d;
            derr_q   <= derr_d;
            dvalid_q <= dvalid_d;
        end
    end

    // Divider next state: accept, one restoring step per cycle, then fixup
    always_comb begin
        dstate_d = dstate_q;
        dcnt_d   = dcnt_q;
        drem_d   = drem_q;
        dquo_d   = dquo_q;
        dmag_d   = dmag_q;
        dend_d   = dend_q;
        dqneg_d  = dqneg_q;
        drneg_d  = drneg_q;
        dzero_d  = dzero_q;
        dq_out_d = dq_out_q;
        dr_out_d = dr_out_q;
        derr_d   = derr_q;
        dvalid_d = 1'b0;
        // Partial remainder stays below the divisor, so the shifted value is
        // below twice the divisor and SIZE+1 bits hold it.
        dshift   = {drem_q, dquo_q[SIZE-1]};
        ddiff    = dshift - {1'b0, dmag_q};
        dge      = (dshift >= {1'b0, dmag_q});
        case (dstate_q)
            IDLE: begin
                if (div_start) begin
                    dstate_d = BUSY;
                    dcnt_d   = '0;
`ifdef ITER_MULDIV_FAST_DIVZERO_EN
                    // Jump straight to the fixup edge; zero-divisor results
                    // do not depend on the iteration state.
                    if (div_divisor == '0) dcnt_d = LAST;
`endif
                    drem_d   = '0;
                    dquo_d   = mag(div_dividend, div_is_signed);
                    dmag_d   = mag(div_divisor, div_is_signed);
                    dend_d   = div_dividend;
                    dqneg_d  = div_is_signed & (div_dividend[SIZE-1] ^ div_divisor[SIZE-1]);
                    drneg_d  = div_is_signed & div_dividend[SIZE-1];
                    dzero_d  = (div_divisor == '0);
                end
            end
            BUSY: begin
                if (dcnt_q == LAST) begin
                    if (dzero_q) begin
                        dq_out_d = '1;
                        dr_out_d = dend_q;
                        derr_d   = 1'b1;
                    end else begin
                        // Most-negative / -1 lands here too: the magnitude
                        // quotient 2^(SIZE-1) negates back to the dividend.
                        dq_out_d = dqneg_q ? -dquo_q : dquo_q;
                        dr_out_d = drneg_q ? -drem_q : drem_q;
                        derr_d   = 1'b0;
                    end
                    dvalid_d = 1'b1;
                    dstate_d = IDLE;
                end else begin
                    drem_d = dge ? ddiff[SIZE-1:0] : dshift[SIZE-1:0];
                    dquo_d = {dquo_q[SIZE-2:0], dge};
                    dcnt_d = dcnt_q + CW'(1);
                end
            end
            default: dstate_d = IDLE;
        endcase
    end

    assign div_ready     = (dstate_q == IDLE);
    assign div_valid     = dvalid_q;
    assign div_error     = derr_q;
    assign div_quotient  = dq_out_q;
    assign div_remainder = dr_out_q;

endmodule

// File: tb/tb_iter_muldiv.sv
// Directed bench for iter_muldiv at SIZE=33 (RV32M operand width).
module tb_iter_muldiv;

    localparam int SIZE = 33;
    localparam int LAT  = SIZE + 1;
`ifdef ITER_MULDIV_FAST_DIVZERO_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = SIZE + 1;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              mul_start = 1'b0;
    logic              mul_is_signed = 1'b0;
    logic [SIZE-1:0]   mul_multiplicand = '0;
    logic [SIZE-1:0]   mul_multiplier = '0;
    logic              mul_ready;
    logic              mul_valid;
    logic [2*SIZE-1:0] mul_product;
    logic              div_start = 1'b0;
    logic              div_is_signed = 1'b0;
    logic [SIZE-1:0]   div_dividend = '0;
    logic [SIZE-1:0]   div_divisor = '0;
    logic              div_ready;
    logic              div_valid;
    logic              div_error;
    logic [SIZE-1:0]   div_quotient;
    logic [SIZE-1:0]   div_remainder;

    int n_cmp = 0;
    int n_bad = 0;

    iter_muldiv #(.SIZE(SIZE)) dut (
        .clk(clk), .rst_n(rst_n),
        .mul_start(mul_start), .mul_is_signed(mul_is_signed),
        .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
        .mul_ready(mul_ready), .mul_valid(mul_valid), .mul_product(mul_product),
        .div_start(div_start), .div_is_signed(div_is_signed),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_ready(div_ready), .div_valid(div_valid), .div_error(div_error),
        .div_quotient(div_quotient), .div_remainder(div_remainder)
    );

    always #5 clk = ~clk;

    // Start a divide, wait (bounded) for div_valid; lat = edges after accept or -1.
    task automatic run_div(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input logic s,
                           output logic [SIZE-1:0] q, output logic [SIZE-1:0] r,
                           output logic e, output int lat);
        @(negedge clk);
        div_dividend = a; div_divisor = b; div_is_signed = s; div_start = 1'b1;
        @(posedge clk); #1;
        div_start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (div_valid) begin lat = i; break; end
        end
        q = div_quotient; r = div_remainder; e = div_error;
        $display("div a=%h b=%h s=%0d -> q=%h r=%h e=%0d lat=%0d", a, b, s, q, r, e, lat);
    endtask

    // Start a multiply, wait (bounded) for mul_valid.
    task automatic run_mul(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input logic s,
                           output logic [2*SIZE-1:0] p, output int lat);
        @(negedge clk);
        mul_multiplicand = a; mul_multiplier = b; mul_is_signed = s; mul_start = 1'b1;
        @(posedge clk); #1;
        mul_start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (mul_valid) begin lat = i; break; end
        end
        p = mul_product;
        $display("mul a=%h b=%h s=%0d -> p=%h lat=%0d", a, b, s, p, lat);
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (mul_ready !== 1'b1 || mul_valid !== 1'b0 || mul_product !== '0) begin
            n_bad++; $display("FAIL reset_mul: ready=%b valid=%b prod=%h, want 1 0 0", mul_ready, mul_valid, mul_product);
        end
        n_cmp++;
        if (div_ready !== 1'b1 || div_valid !== 1'b0 || div_error !== 1'b0 ||
            div_quotient !== '0 || div_remainder !== '0) begin
            n_bad++; $display("FAIL reset_div: ready=%b valid=%b err=%b q=%h r=%h, want 1 0 0 0 0",
                              div_ready, div_valid, div_error, div_quotient, div_remainder);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_div();
        logic [SIZE-1:0] q, r; logic e; int lat;
        run_div(33'd100, 33'd7, 1'b0, q, r, e, lat);
        n_cmp++;
        if (lat !== LAT) begin n_bad++; $display("FAIL div_latency: got %0d want %0d", lat, LAT); end
        n_cmp++;
        if (q !== 33'd14 || r !== 33'd2 || e !== 1'b0) begin
            n_bad++; $display("FAIL div_100_7: q=%h r=%h e=%b want 0e 02 0", q, r, e);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (div_valid !== 1'b0) begin n_bad++; $display("FAIL div_valid_pulse: valid=%b want 0", div_valid); end

        run_div(33'h1FFFFFFF9, 33'd2, 1'b1, q, r, e, lat);
        n_cmp++;
        if (q !== 33'h1FFFFFFFD || r !== 33'h1FFFFFFFF || e !== 1'b0) begin
            n_bad++; $display("FAIL div_m7_2: q=%h r=%h e=%b want 1fffffffd 1ffffffff 0", q, r, e);
        end
        run_div(33'd7, 33'h1FFFFFFFE, 1'b1, q, r, e, lat);
        n_cmp++;
        if (q !== 33'h1FFFFFFFD || r !== 33'd1 || e !== 1'b0) begin
            n_bad++; $display("FAIL div_7_m2: q=%h r=%h e=%b want 1fffffffd 1 0", q, r, e);
        end
    endtask

    task automatic test_div_edge();
        logic [SIZE-1:0] q, r; logic e; int lat;
        run_div(33'd5, 33'd0, 1'b0, q, r, e, lat);
        n_cmp++;
        if (q !== 33'h1FFFFFFFF || r !== 33'd5 || e !== 1'b1) begin
            n_bad++; $display("FAIL div_by_zero: q=%h r=%h e=%b want 1ffffffff 5 1", q, r, e);
        end
        n_cmp++;
        if (lat !== ZLAT) begin n_bad++; $display("FAIL div_zero_latency: got %0d want %0d", lat, ZLAT); end
        run_div(33'h1FFFFFFF9, 33'd0, 1'b1, q, r, e, lat);
        n_cmp++;
        if (q !== 33'h1FFFFFFFF || r !== 33'h1FFFFFFF9 || e !== 1'b1) begin
            n_bad++; $display("FAIL div_neg_by_zero: q=%h r=%h e=%b want 1ffffffff 1fffffff9 1", q, r, e);
        end
        run_div(33'h100000000, 33'h1FFFFFFFF, 1'b1, q, r, e, lat);
        n_cmp++;
        if (q !== 33'h100000000 || r !== 33'd0 || e !== 1'b0) begin
            n_bad++; $display("FAIL div_overflow: q=%h r=%h e=%b want 100000000 0 0", q, r, e);
        end
        n_cmp++;
        if (lat !== LAT) begin n_bad++; $display("FAIL div_overflow_latency: got %0d want %0d", lat, LAT); end
    endtask

    task automatic test_mul();
        logic [2*SIZE-1:0] p; int lat;
        run_mul(33'h0FFFFFFFF, 33'h0FFFFFFFF, 1'b0, p, lat);
        n_cmp++;
        if (p !== 66'h0_FFFF_FFFE_0000_0001) begin
            n_bad++; $display("FAIL mul_unsigned_max: got %h want 0fffffffe00000001", p);
        end
        n_cmp++;
        if (lat !== LAT) begin n_bad++; $display("FAIL mul_latency: got %0d want %0d", lat, LAT); end
        run_mul(33'h1FFFFFFFD, 33'd5, 1'b1, p, lat);
        n_cmp++;
        if (p !== 66'h3_FFFF_FFFF_FFFF_FFF1) begin
            n_bad++; $display("FAIL mul_m3_5: got %h want 3fffffffffffffff1", p);
        end
        run_mul(33'h1FFFFFFFF, 33'h000000002, 1'b1, p, lat);
        n_cmp++;
        if (p !== 66'h3_FFFF_FFFF_FFFF_FFFE) begin
            n_bad++; $display("FAIL mul_hsu: got %h want 3fffffffffffffffe", p);
        end
    endtask

    task automatic test_start_held();
        int pulses = 0;
        @(negedge clk);
        mul_multiplicand = 33'd6; mul_multiplier = 33'd7; mul_is_signed = 1'b0; mul_start = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (mul_ready !== 1'b0) begin n_bad++; $display("FAIL ready_after_accept: ready=%b want 0", mul_ready); end
        repeat (2) @(posedge clk);
        #1 mul_start = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (mul_valid) pulses++;
        end
        n_cmp++;
        if (pulses !== 1 || mul_product !== 66'd42) begin
            n_bad++; $display("FAIL start_held: pulses=%0d prod=%h want 1 2a", pulses, mul_product);
        end
        $display("start held 3 cycles: pulses=%0d prod=%h", pulses, mul_product);
    endtask

    task automatic test_busy_ignored();
        int pulses = 0; int lat = -1;
        @(negedge clk);
        mul_multiplicand = 33'd3; mul_multiplier = 33'd4; mul_start = 1'b1;
        @(posedge clk); #1 mul_start = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            if (i == 5) begin
                mul_multiplicand = 33'd9; mul_multiplier = 33'd9; mul_start = 1'b1;
            end
            @(posedge clk); #1;
            mul_start = 1'b0;
            if (mul_valid) begin pulses++; if (lat < 0) lat = i; end
        end
        n_cmp++;
        if (pulses !== 1 || lat !== LAT || mul_product !== 66'd12) begin
            n_bad++; $display("FAIL busy_ignored: pulses=%0d lat=%0d prod=%h want 1 %0d c", pulses, lat, mul_product, LAT);
        end
        $display("start while busy: pulses=%0d lat=%0d prod=%h", pulses, lat, mul_product);
    endtask

    task automatic test_back_to_back();
        logic [2*SIZE-1:0] p; int lat;
        run_mul(33'd10, 33'd11, 1'b0, p, lat);
        // Still within the valid cycle: request the next operation now.
        n_cmp++;
        if (mul_ready !== 1'b1) begin n_bad++; $display("FAIL ready_on_valid: ready=%b want 1", mul_ready); end
        mul_multiplicand = 33'd12; mul_multiplier = 33'd13; mul_start = 1'b1;
        @(posedge clk); #1 mul_start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (mul_valid) begin lat = i; break; end
        end
        n_cmp++;
        if (lat !== LAT || mul_product !== 66'd156) begin
            n_bad++; $display("FAIL back_to_back: lat=%0d prod=%h want %0d 9c", lat, mul_product, LAT);
        end
        $display("back-to-back: prev=%h next=%h lat=%0d", p, mul_product, lat);
    endtask

    task automatic test_concurrent();
        int mlat = -1; int dlat = -1;
        logic [2*SIZE-1:0] p = '0; logic [SIZE-1:0] q = '0; logic [SIZE-1:0] r = '0;
        @(negedge clk);
        mul_multiplicand = 33'h1FFFFFFF8; mul_multiplier = 33'd9; mul_is_signed = 1'b1; mul_start = 1'b1;
        div_dividend = 33'd1000; div_divisor = 33'd33; div_is_signed = 1'b0; div_start = 1'b1;
        @(posedge clk); #1 begin mul_start = 1'b0; div_start = 1'b0; end
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (mul_valid && mlat < 0) begin mlat = i; p = mul_product; end
            if (div_valid && dlat < 0) begin dlat = i; q = div_quotient; r = div_remainder; end
            if (mlat > 0 && dlat > 0) break;
        end
        n_cmp++;
        if (mlat !== LAT || p !== 66'h3_FFFF_FFFF_FFFF_FFB8) begin
            n_bad++; $display("FAIL concurrent_mul: lat=%0d prod=%h want %0d 3ffffffffffffffb8", mlat, p, LAT);
        end
        n_cmp++;
        if (dlat !== LAT || q !== 33'd30 || r !== 33'd10) begin
            n_bad++; $display("FAIL concurrent_div: lat=%0d q=%h r=%h want %0d 1e a", dlat, q, r, LAT);
        end
        $display("concurrent: prod=%h q=%h r=%h", p, q, r);
    endtask

    task automatic test_reset_mid();
        logic [2*SIZE-1:0] p; int lat; int pulses = 0;
        @(negedge clk);
        mul_multiplicand = 33'd100; mul_multiplier = 33'd100; mul_is_signed = 1'b0; mul_start = 1'b1;
        @(posedge clk); #1 mul_start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (mul_ready !== 1'b1 || mul_valid !== 1'b0 || mul_product !== '0) begin
            n_bad++; $display("FAIL reset_mid: ready=%b valid=%b prod=%h want 1 0 0", mul_ready, mul_valid, mul_product);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (mul_valid) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin n_bad++; $display("FAIL reset_no_valid: pulses=%0d want 0", pulses); end
        run_mul(33'd100, 33'd100, 1'b0, p, lat);
        n_cmp++;
        if (p !== 66'd10000 || lat !== LAT) begin
            n_bad++; $display("FAIL after_reset: prod=%h lat=%0d want 2710 %0d", p, lat, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_div();
        test_div_edge();
        test_mul();
        test_start_held();
        test_busy_ignored();
        test_back_to_back();
        test_concurrent();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
